// File: rtl/axi_single_initiator_pkg.sv
// Shared AXI encodings, initiator FSM states and the store mask-to-size helper
// used by both the AXI initiator and the core's LSU.
package axi_single_initiator_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  // Single byte -> 0, aligned halfword -> 1, anything else (incl. empty) -> word.
  function automatic logic [2:0] mask_to_size(input logic [3:0] mask);
    logic [2:0] size;
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
      4'b0011, 4'b1100:                   size = 3'd1;
      default:                            size = 3'd2;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/axi_single_initiator_resp_check.sv
// Response qualifier shared by the R and B channels: flags a non-OKAY response,
// a foreign ID, or a missing last marker.
module axi_resp_check
  import axi_single_initiator_pkg::*;
#(
  parameter logic [7:0] EXPECT_ID = 8'h00
) (
  input  logic [7:0] id,
  input  logic [1:0] resp,
  input  logic       last,
  output logic       err
);

  assign err = (resp != RESP_OKAY) || (id != EXPECT_ID) || !last;

endmodule

// File: rtl/axi_single_initiator.sv
// Single-outstanding AXI4 initiator: turns one load/store request into a
// one-beat AXI read or write and returns a one-cycle response pulse.
module axi_single_initiator
  import axi_single_initiator_pkg::*;
#(
  parameter logic [7:0] AXI_ID = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  ar_id,
  output logic [31:0] ar_addr,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  output logic        ar_valid,
  input  logic        ar_ready,
  input  logic [7:0]  r_id,
  input  logic [1:0]  r_resp,
  input  logic [31:0] r_data,
  input  logic        r_last,
  input  logic        r_valid,
  output logic        r_ready,
  output logic [7:0]  aw_id,
  output logic [31:0] aw_addr,
  output logic [7:0]  aw_len,
  output logic [2:0]  aw_size,
  output logic [1:0]  aw_burst,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  output logic        w_last,
  output logic        w_valid,
  input  logic        w_ready,
  input  logic [7:0]  b_id,
  input  logic [1:0]  b_resp,
  input  logic        b_valid,
  output logic        b_ready
);

  state_t      state_r, state_next;
  logic        aw_done_r, w_done_r, aw_done_next, w_done_next;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  wmask_r;
  logic [2:0]  ar_size_r, aw_size_r;
  logic        accept_s, ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
  logic        rd_err_s, wr_err_s;

  assign accept_s = (state_r == ST_IDLE) && req_valid && req_ready;
  assign ar_hs_s  = ar_valid && ar_ready;
  assign r_hs_s   = r_ready && r_valid;
  assign aw_hs_s  = aw_valid && aw_ready;
  assign w_hs_s   = w_valid && w_ready;
  assign b_hs_s   = b_ready && b_valid;

  assign ar_id    = AXI_ID;
  assign ar_len   = 8'd0;
  assign ar_burst = BURST_INCR;
  assign ar_addr  = addr_r;
  assign ar_size  = ar_size_r;
  assign aw_id    = AXI_ID;
  assign aw_len   = 8'd0;
  assign aw_burst = BURST_INCR;
  assign aw_addr  = addr_r;
  assign aw_size  = aw_size_r;
  assign w_data   = wdata_r;
  assign w_strb   = wmask_r;
  assign w_last   = 1'b1;

  axi_resp_check #(.EXPECT_ID(AXI_ID)) u_rd_check (
    .id(r_id), .resp(r_resp), .last(r_last), .err(rd_err_s)
  );

  axi_resp_check #(.EXPECT_ID(AXI_ID)) u_wr_check (
    .id(b_id), .resp(b_resp), .last(1'b1), .err(wr_err_s)
  );

  // Next-state logic; AW and W completion are tracked independently.
  always_comb begin
    state_next   = state_r;
    aw_done_next = aw_done_r;
    w_done_next  = w_done_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next   = req_we ? ST_WR_REQ : ST_RD_ADDR;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (ar_hs_s) state_next = ST_RD_DATA;
        else         state_next = ST_RD_ADDR;
      end
      ST_RD_DATA: begin
        if (r_hs_s) state_next = ST_RESP;
        else        state_next = ST_RD_DATA;
      end
      ST_WR_REQ: begin
        aw_done_next = aw_done_r || aw_hs_s;
        w_done_next  = w_done_r || w_hs_s;
        if (aw_done_next && w_done_next) state_next = ST_WR_RESP;
        else                             state_next = ST_WR_REQ;
      end
      ST_WR_RESP: begin
        if (b_hs_s) state_next = ST_RESP;
        else        state_next = ST_WR_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, request latches and every handshake output are registered from next-state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      req_ready  <= 1'b0;
      ar_valid   <= 1'b0;
      r_ready    <= 1'b0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      b_ready    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      wmask_r    <= 4'h0;
      ar_size_r  <= 3'd0;
      aw_size_r  <= 3'd0;
    end else begin
      state_r    <= state_next;
      aw_done_r  <= aw_done_next;
      w_done_r   <= w_done_next;
      req_ready  <= (state_next == ST_IDLE);
      ar_valid   <= (state_next == ST_RD_ADDR);
      r_ready    <= (state_next == ST_RD_DATA);
      aw_valid   <= (state_next == ST_WR_REQ) && !aw_done_next;
      w_valid    <= (state_next == ST_WR_REQ) && !w_done_next;
      b_ready    <= (state_next == ST_WR_RESP);
      resp_valid <= (state_next == ST_RESP);
      if (accept_s) begin
        addr_r    <= req_addr;
        wdata_r   <= req_wdata;
        wmask_r   <= req_wmask;
        ar_size_r <= (req_size == 2'd3) ? 3'd2 : {1'b0, req_size};
        aw_size_r <= mask_to_size(req_wmask);
      end else begin
        addr_r    <= addr_r;
        wdata_r   <= wdata_r;
        wmask_r   <= wmask_r;
        ar_size_r <= ar_size_r;
        aw_size_r <= aw_size_r;
      end
      // Response fields are only non-zero alongside resp_valid.
      if (r_hs_s) begin
        resp_rdata <= r_data;
        resp_err   <= rd_err_s;
      end else if (b_hs_s) begin
        resp_rdata <= 32'h0000_0000;
        resp_err   <= wr_err_s;
      end else begin
        resp_rdata <= 32'h0000_0000;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_single_initiator.sv
// Scoreboard bench for axi_single_initiator: directed requests against a
// configurable AXI responder; a monitor checks every response pulse.
module tb_axi_single_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [3:0]  req_wmask;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  ar_id, ar_len, r_id, aw_id, aw_len, b_id;
  logic [31:0] ar_addr, r_data, aw_addr, w_data;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, r_resp, aw_burst, b_resp;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic [3:0]  w_strb;

  axi_single_initiator #(.AXI_ID(8'h00)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_resp(r_resp), .r_data(r_data), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];

  // Responder configuration for the next transaction.
  int          cfg_ar_wait = 0, cfg_r_wait = 0, cfg_aw_wait = 0, cfg_w_wait = 0;
  logic [31:0] cfg_r_data = 32'h0;
  logic [1:0]  cfg_r_resp = 2'b00, cfg_b_resp = 2'b00;
  logic [7:0]  cfg_r_id = 8'h00, cfg_b_id = 8'h00;
  logic        cfg_r_last = 1'b1;

  // Observed request-side channel contents.
  int          ar_cyc, aw_cyc, w_cyc;
  logic [2:0]  ar_size_seen, aw_size_seen;
  logic [31:0] ar_addr_seen, w_data_seen;
  logic [3:0]  w_strb_seen;
  logic [7:0]  ar_len_seen;
  logic [1:0]  ar_burst_seen;
  logic        w_last_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  // Responder: decisions made on the falling edge take effect at the next rising edge.
  initial begin : responder
    int   ar_cnt, r_cnt, aw_cnt, w_cnt;
    logic rd_pend, aw_got, w_got, ar_f, r_f, aw_f, w_f, b_f;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
    rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    ar_f = 1'b0; r_f = 1'b0; aw_f = 1'b0; w_f = 1'b0; b_f = 1'b0;
    ar_ready = 1'b0; r_valid = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
    r_data = 32'h0; r_resp = 2'b00; r_id = 8'h00; r_last = 1'b0; b_resp = 2'b00; b_id = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
        rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        ar_ready = 1'b0; r_valid = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
      end else begin
        if (ar_f) begin ar_ready = 1'b0; ar_cnt = 0; rd_pend = 1'b1; r_cnt = 0; end
        if (r_f)  begin r_valid = 1'b0; rd_pend = 1'b0; end
        if (aw_f) begin aw_ready = 1'b0; aw_cnt = 0; aw_got = 1'b1; end
        if (w_f)  begin w_ready = 1'b0; w_cnt = 0; w_got = 1'b1; end
        if (b_f)  begin b_valid = 1'b0; aw_got = 1'b0; w_got = 1'b0; end
        if (ar_valid && !ar_ready) begin
          if (ar_cnt >= cfg_ar_wait) ar_ready = 1'b1; else ar_cnt++;
        end
        if (rd_pend && !r_valid) begin
          if (r_cnt >= cfg_r_wait) begin
            r_valid = 1'b1; r_data = cfg_r_data; r_resp = cfg_r_resp;
            r_id = cfg_r_id; r_last = cfg_r_last;
          end else r_cnt++;
        end
        if (aw_valid && !aw_ready) begin
          if (aw_cnt >= cfg_aw_wait) aw_ready = 1'b1; else aw_cnt++;
        end
        if (w_valid && !w_ready) begin
          if (w_cnt >= cfg_w_wait) w_ready = 1'b1; else w_cnt++;
        end
        if (aw_got && w_got && !b_valid) begin
          b_valid = 1'b1; b_resp = cfg_b_resp; b_id = cfg_b_id;
        end
      end
      ar_f = ar_valid && ar_ready;
      r_f  = r_valid && r_ready;
      aw_f = aw_valid && aw_ready;
      w_f  = w_valid && w_ready;
      b_f  = b_valid && b_ready;
    end
  end

  // Channel watcher: records what the initiator presents while each valid is high.
  initial begin
    forever begin
      @(negedge clk);
      if (ar_valid) begin
        ar_cyc++; ar_size_seen = ar_size; ar_addr_seen = ar_addr;
        ar_len_seen = ar_len; ar_burst_seen = ar_burst;
      end
      if (aw_valid) begin aw_cyc++; aw_size_seen = aw_size; end
      if (w_valid) begin
        w_cyc++; w_data_seen = w_data; w_strb_seen = w_strb; w_last_seen = w_last;
      end
    end
  end

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_unexpected: resp_valid with rdata 0x%08h err %b, required no response",
                   resp_rdata, resp_err);
        end else begin
          e = exp_q.pop_front();
          check("sb_rdata", 64'(resp_rdata), 64'(e[31:0]));
          check("sb_err", 64'(resp_err), 64'(e[32]));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wd, input logic [3:0] m,
                       input logic [31:0] exp_rdata, input logic exp_err, output int lat);
    int n, t0;
    ar_cyc = 0; aw_cyc = 0; w_cyc = 0;
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_wdata = wd; req_wmask = m;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("req_ready_timeout", 64'(0), 64'(1));
      req_valid = 1'b0;
      void'(exp_q.pop_back());
      lat = -1;
      return;
    end
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    if (!resp_valid) check("resp_timeout", 64'(0), 64'(1));
    lat = cyc - t0;
  endtask

  initial begin
    int lat, n;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'd0; req_wdata = 32'h0; req_wmask = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({req_ready, ar_valid, r_ready, aw_valid, w_valid, b_ready, resp_valid, resp_err}),
          64'(8'h00));
    check("rst_rdata", 64'(resp_rdata), 64'(32'h0));
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(1));

    // 1: byte read, zero-wait responder
    cfg_r_data = 32'h0000_00A5;
    issue(1'b0, 32'hBFD0_03F8, 2'd0, 32'h0, 4'h0, 32'h0000_00A5, 1'b0, lat);
    check("rd_ar_size", 64'(ar_size_seen), 64'(3'd0));
    check("rd_ar_addr", 64'(ar_addr_seen), 64'(32'hBFD0_03F8));
    check("rd_ar_len_burst", 64'({ar_len_seen, ar_burst_seen}), 64'({8'd0, 2'b01}));
    check("rd_ar_cycles", 64'(ar_cyc), 64'(1));
    check("rd_latency", 64'(lat), 64'(3));
    @(negedge clk);
    check("rd_req_ready_after", 64'(req_ready), 64'(1));

    // 2: byte write, AW stalled 3 cycles, W immediate
    cfg_aw_wait = 3;
    issue(1'b1, 32'hBFD0_03F8, 2'd2, 32'h0000_0041, 4'b0001, 32'h0, 1'b0, lat);
    check("wr_aw_size", 64'(aw_size_seen), 64'(3'd0));
    check("wr_aw_cycles", 64'(aw_cyc), 64'(4));
    check("wr_w_cycles", 64'(w_cyc), 64'(1));
    check("wr_w_fields", 64'({w_data_seen, w_strb_seen, w_last_seen}), 64'({32'h0000_0041, 4'b0001, 1'b1}));
    check("wr_latency", 64'(lat), 64'(6));
    cfg_aw_wait = 0;

    // zero-wait full-word write, W stalled 2 cycles
    cfg_w_wait = 2;
    issue(1'b1, 32'h0000_1000, 2'd2, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, lat);
    check("wr2_aw_size", 64'(aw_size_seen), 64'(3'd2));
    check("wr2_cycles", 64'({aw_cyc[7:0], w_cyc[7:0]}), 64'({8'd1, 8'd3}));
    check("wr2_latency", 64'(lat), 64'(5));
    cfg_w_wait = 0;

    // 3: SLVERR read still forwards data; halfword size
    cfg_r_resp = 2'b10; cfg_r_data = 32'hDEAD_BEEF;
    issue(1'b0, 32'h0000_2002, 2'd1, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, lat);
    check("rd_slverr_size", 64'(ar_size_seen), 64'(3'd1));
    // missing r_last, size 3 clamped to word
    cfg_r_resp = 2'b00; cfg_r_last = 1'b0; cfg_r_data = 32'h5A5A_0000;
    issue(1'b0, 32'h0000_2004, 2'd3, 32'h0, 4'h0, 32'h5A5A_0000, 1'b1, lat);
    check("rd_clamp_size", 64'(ar_size_seen), 64'(3'd2));
    // foreign read ID
    cfg_r_last = 1'b1; cfg_r_id = 8'h03; cfg_r_data = 32'h0000_0011;
    issue(1'b0, 32'h0000_2008, 2'd2, 32'h0, 4'h0, 32'h0000_0011, 1'b1, lat);
    // clean read with a 2-cycle R stall
    cfg_r_id = 8'h00; cfg_r_wait = 2; cfg_r_data = 32'h8765_4321;
    issue(1'b0, 32'h0000_200C, 2'd2, 32'h0, 4'h0, 32'h8765_4321, 1'b0, lat);
    check("rd_stall_latency", 64'(lat), 64'(5));
    cfg_r_wait = 0;

    // 4: foreign write-response ID
    cfg_b_id = 8'h05;
    issue(1'b1, 32'h0000_3000, 2'd2, 32'hAAAA_5555, 4'b1100, 32'h0, 1'b1, lat);
    check("wr_bid_aw_size", 64'(aw_size_seen), 64'(3'd1));
    @(negedge clk);
    check("wr_bid_req_ready", 64'(req_ready), 64'(1));
    cfg_b_id = 8'h00;

    // empty mask issues as a word with zero strobe; DECERR flagged
    cfg_b_resp = 2'b11;
    issue(1'b1, 32'h0000_3004, 2'd2, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b1, lat);
    check("wr_mask0_size", 64'(aw_size_seen), 64'(3'd2));
    check("wr_mask0_strb", 64'(w_strb_seen), 64'(4'b0000));
    cfg_b_resp = 2'b00;
    issue(1'b1, 32'h0000_3008, 2'd2, 32'h0000_BEEF, 4'b0011, 32'h0, 1'b0, lat);
    check("wr_mask3_size", 64'(aw_size_seen), 64'(3'd1));
    issue(1'b1, 32'h0000_300C, 2'd2, 32'h00CC_BBAA, 4'b0111, 32'h0, 1'b0, lat);
    check("wr_mask7_size", 64'(aw_size_seen), 64'(3'd2));

    // 5: reset while waiting on a silent R channel
    cfg_r_wait = 1000;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4000; req_size = 2'd2;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!r_ready && n < 50) begin @(negedge clk); n++; end
    check("abort_reached_rd_data", 64'(r_ready), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", 64'({req_ready, ar_valid, r_ready, aw_valid, w_valid, b_ready, resp_valid}),
          64'(7'h00));
    @(negedge clk);
    reset = 1'b0;
    cfg_r_wait = 0; cfg_r_data = 32'hCAFE_F00D;
    @(negedge clk);
    issue(1'b0, 32'h0000_4004, 2'd2, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, lat);
    check("post_abort_latency", 64'(lat), 64'(3));

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
